esm_issue_buffer: RTL and testbench

- Parametrised successor to the ESM instruction buffer and validator pair. It is a circular instruction window with enqueue/issue handshakes, per-entry valid bits and a register scoreboard.
- It issues the oldest hazard-free entry each cycle, which allows out-of-order issue within the window.
- Sits between fetch/decode and the execute stage. Writeback feedback clears pending registers.

---
 rtl/esm_pkg.sv | 31 +++
 rtl/esm_age_picker.sv | 25 ++
 rtl/esm_issue_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_esm_issue_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared definitions for the ESM issue buffer: RV32 field positions, the stored
// window entry layout and the age-ordering helper.
package esm_pkg;

    localparam int RD_LSB      = 7;
    localparam int RS1_LSB     = 15;
    localparam int RS2_LSB     = 20;
    localparam int REG_FIELD_W = 5;
    // Widest instruction word an entry can hold; narrower words are zero-extended.
    localparam int IW_MAX      = 64;

    typedef struct packed {
        logic [IW_MAX-1:0]      instr;
        logic [REG_FIELD_W-1:0] rd;
        logic [REG_FIELD_W-1:0] rs1;
        logic [REG_FIELD_W-1:0] rs2;
        logic                   regwrite;
        logic                   uses_rs2;
    } esm_entry_t;

    // True when slot a is older than slot b in a window of bs slots starting at head.
    function automatic logic esm_is_older(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] head,
                                          input logic [31:0] bs);
        logic [31:0] mask;
        mask = bs - 32'd1;
        return ((a - head) & mask) < ((b - head) & mask);
    endfunction

endpackage

// File: rtl/esm_age_picker.sv
// Rotating priority encoder: returns the first set bit of 'eligible' scanning
// upward from 'head' with wrap-around, i.e. the oldest eligible window slot.
module esm_age_picker #(
    parameter int BS = 16
) (
    input  logic [BS-1:0]         eligible,
    input  logic [$clog2(BS)-1:0] head,
    output logic [$clog2(BS)-1:0] idx,
    output logic                  found
);

    localparam int AW = $clog2(BS);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < BS; k++) begin
            if (!found && eligible[head + AW'(k)]) begin
                found = 1'b1;
                idx   = head + AW'(k);
            end
        end
    end

endmodule

// File: rtl/esm_issue_buffer.sv
// Circular instruction window with a register scoreboard that issues the oldest
// hazard-free entry each cycle. Optional stall counter: define ESM_STALL_CNT_EN.
module esm_issue_buffer
    import esm_pkg::*;
#(
    parameter int IW   = 32,
    parameter int BS   = 16,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IW-1:0]           in_instr,
    input  logic                    in_regwrite,
    input  logic                    in_alusrc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IW-1:0]           out_instr,
    output logic [$clog2(BS)-1:0]   out_tag,
    input  logic                    wb_valid,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    output logic [BS-1:0]           valid_entries,
    output logic [$clog2(BS):0]     occupancy,
    output logic [31:0]             stall_cnt
);

    localparam int AW = $clog2(BS);
    localparam int RW = $clog2(NREG);

    // Pointers carry the wrap flag as their MSB so a plain increment toggles it.
    logic [AW:0]     head_q, head_d;
    logic [AW:0]     tail_q, tail_d;
    logic [BS-1:0]   valid_q, valid_d;
    logic [NREG-1:0] sb_q, sb_d;
    esm_entry_t      entry_q [BS];
    esm_entry_t      entry_d [BS];

    logic [AW-1:0]   head_ptr;
    logic [AW-1:0]   tail_ptr;
    logic            full;
    logic            empty;
    logic            enq_fire;
    logic            iss_fire;
    logic            retire;
    logic [BS-1:0]   eligible;
    logic [AW-1:0]   pick_idx;
    logic            pick_found;
    esm_entry_t      new_entry;
    esm_entry_t      out_entry;
    logic            unused_out_entry;

    function automatic logic [RW-1:0] reg_idx(input logic [REG_FIELD_W-1:0] f);
        return RW'(f);
    endfunction

    function automatic logic srcs_pending(input esm_entry_t e, input logic [NREG-1:0] sb);
        return (e.rs1 != '0 && sb[reg_idx(e.rs1)]) ||
               (e.uses_rs2 && e.rs2 != '0 && sb[reg_idx(e.rs2)]);
    endfunction

    // Hazard of younger entry y against older entry o; x0 never participates.
    function automatic logic pair_hazard(input esm_entry_t y, input esm_entry_t o);
        logic raw;
        logic waw;
        logic war;
        raw = o.regwrite && o.rd != '0 &&
              (o.rd == y.rs1 || (y.uses_rs2 && o.rd == y.rs2));
        waw = y.regwrite && y.rd != '0 && o.regwrite && o.rd == y.rd;
        war = y.regwrite && y.rd != '0 &&
              (o.rs1 == y.rd || (o.uses_rs2 && o.rs2 == y.rd));
        return raw || waw || war;
    endfunction

    assign head_ptr = head_q[AW-1:0];
    assign tail_ptr = tail_q[AW-1:0];
    assign full     = (head_ptr == tail_ptr) && (head_q[AW] != tail_q[AW]);
    assign empty    = (head_q == tail_q);

    always_comb begin
        new_entry.instr    = IW_MAX'(in_instr);
        new_entry.rd       = in_instr[RD_LSB +: REG_FIELD_W];
        new_entry.rs1      = in_instr[RS1_LSB +: REG_FIELD_W];
        new_entry.rs2      = in_instr[RS2_LSB +: REG_FIELD_W];
        new_entry.regwrite = in_regwrite;
        new_entry.uses_rs2 = !in_alusrc;
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < BS; i++) begin
            if (valid_q[i] && !srcs_pending(entry_q[i], sb_q)) begin
                eligible[i] = 1'b1;
                for (int j = 0; j < BS; j++) begin
                    if (valid_q[j] &&
                        esm_is_older(32'(j), 32'(i), 32'(head_ptr), 32'(BS)) &&
                        pair_hazard(entry_q[i], entry_q[j])) begin
                        eligible[i] = 1'b0;
                    end
                end
            end
        end
    end

    esm_age_picker #(
        .BS(BS)
    ) u_picker (
        .eligible(eligible),
        .head    (head_ptr),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    assign out_entry        = entry_q[pick_idx];
    assign unused_out_entry = ^out_entry;

    assign enq_fire = in_valid && !full;
    assign iss_fire = pick_found && out_ready;
    assign retire   = !empty && !valid_q[head_ptr];

    always_comb begin
        head_d  = retire ? head_q + 1'b1 : head_q;
        tail_d  = enq_fire ? tail_q + 1'b1 : tail_q;
        valid_d = valid_q;
        if (iss_fire) begin
            valid_d[pick_idx] = 1'b0;
        end
        if (enq_fire) begin
            valid_d[tail_ptr] = 1'b1;
        end
    end

    // Writeback clears first so a same-cycle issue to the same register wins.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (iss_fire && out_entry.regwrite && out_entry.rd != '0) begin
            sb_d[reg_idx(out_entry.rd)] = 1'b1;
        end
    end

    always_comb begin
        entry_d = entry_q;
        if (enq_fire) begin
            entry_d[tail_ptr] = new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            sb_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            sb_q    <= sb_d;
        end
    end

    // Payload storage needs no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign in_ready      = !full;
    assign out_valid     = pick_found;
    assign out_tag       = pick_found ? pick_idx : '0;
    assign out_instr     = pick_found ? out_entry.instr[IW-1:0] : '0;
    assign valid_entries = valid_q;
    assign occupancy     = tail_q - head_q;

`ifdef ESM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|valid_q) && !iss_fire && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Self-checking bench for esm_issue_buffer: directed scenarios plus random
// traffic, every cycle compared against an age-ordered queue reference model.
module tb_esm_issue_buffer;

    localparam int IW   = 32;
    localparam int BS   = 16;
    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_regwrite;
    logic        in_alusrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_tag;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [15:0] valid_entries;
    logic [4:0]  occupancy;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    esm_issue_buffer #(
        .IW  (IW),
        .BS  (BS),
        .NREG(NREG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_regwrite  (in_regwrite),
        .in_alusrc    (in_alusrc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_tag      (out_tag),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .valid_entries(valid_entries),
        .occupancy    (occupancy),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        int          tag;
        bit          issued;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          rw;
        bit          use2;
    } mEntry;

    // Reference model: window entries in age order, issued ones kept as holes.
    mEntry       mq[$];
    logic [31:0] mSb;
    int          tailCnt;
    longint      mStall;
    bit          expValid;
    int          expIdx;
    int          expTag;
    logic [31:0] expInstr;

    int passCount;
    int totalCount;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkInstr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic bit mEligible(input int k);
        mEntry e;
        mEntry o;
        bit    ok;
        e  = mq[k];
        ok = 1'b1;
        if (e.rs1 != 0 && mSb[e.rs1]) ok = 1'b0;
        if (e.use2 && e.rs2 != 0 && mSb[e.rs2]) ok = 1'b0;
        for (int m = 0; m < k; m++) begin
            o = mq[m];
            if (!o.issued) begin
                if (o.rw && o.rd != 0 && (o.rd == e.rs1 || (e.use2 && o.rd == e.rs2))) ok = 1'b0;
                if (e.rw && e.rd != 0 &&
                    ((o.rw && o.rd == e.rd) || o.rs1 == e.rd || (o.use2 && o.rs2 == e.rd))) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    task automatic computeExpected();
        expValid = 1'b0;
        expIdx   = -1;
        expTag   = 0;
        expInstr = '0;
        for (int k = 0; k < mq.size(); k++) begin
            if (!expValid && !mq[k].issued && mEligible(k)) begin
                expValid = 1'b1;
                expIdx   = k;
                expTag   = mq[k].tag;
                expInstr = mq[k].instr;
            end
        end
    endtask

    task automatic compareAll();
        logic [15:0] mask;
        longint      expStall;
        computeExpected();
        mask = '0;
        for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].issued) mask[mq[k].tag] = 1'b1;
        end
`ifdef ESM_STALL_CNT_EN
        expStall = mStall;
`else
        expStall = 0;
`endif
        checkOutput("in_ready",      64'(in_ready),      64'(mq.size() < BS));
        checkOutput("occupancy",     64'(occupancy),     64'(mq.size()));
        checkOutput("valid_entries", 64'(valid_entries), 64'(mask));
        checkOutput("out_valid",     64'(out_valid),     64'(expValid));
        checkOutput("out_tag",       64'(out_tag),       64'(expTag));
        checkOutput("out_instr",     64'(out_instr),     64'(expInstr));
        checkOutput("stall_cnt",     64'(stall_cnt),     64'(expStall));
    endtask

    task automatic updateModel(input bit v, input logic [31:0] ins, input bit rw, input bit as,
                               input bit ordy, input bit wbv, input logic [4:0] wbr);
        bit    full;
        bit    retire;
        bit    fire;
        bit    anyLive;
        mEntry tmp;
        full    = (mq.size() == BS);
        retire  = (mq.size() > 0) && mq[0].issued;
        fire    = expValid && ordy;
        anyLive = 1'b0;
        for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].issued) anyLive = 1'b1;
        end
        if (anyLive && !fire && mStall < 64'hFFFF_FFFF) mStall++;
        if (wbv) mSb[wbr] = 1'b0;
        if (fire) begin
            tmp        = mq[expIdx];
            tmp.issued = 1'b1;
            mq[expIdx] = tmp;
            if (tmp.rw && tmp.rd != 0) mSb[tmp.rd] = 1'b1;
        end
        if (retire) void'(mq.pop_front());
        if (v && !full) begin
            tmp.instr  = ins;
            tmp.tag    = tailCnt % BS;
            tmp.issued = 1'b0;
            tmp.rd     = ins[11:7];
            tmp.rs1    = ins[19:15];
            tmp.rs2    = ins[24:20];
            tmp.rw     = rw;
            tmp.use2   = !as;
            mq.push_back(tmp);
            tailCnt++;
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit rw, input bit as,
                                 input bit ordy, input bit wbv, input logic [4:0] wbr);
        in_valid    = v;
        in_instr    = ins;
        in_regwrite = rw;
        in_alusrc   = as;
        out_ready   = ordy;
        wb_valid    = wbv;
        wb_rd       = wbr;
        @(negedge clk);
        compareAll();
        @(posedge clk);
        updateModel(v, ins, rw, as, ordy, wbv, wbr);
        #1;
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wb_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready",      64'(in_ready),      64'(1));
        checkOutput("rst_occupancy",     64'(occupancy),     64'(0));
        checkOutput("rst_valid_entries", 64'(valid_entries), 64'(0));
        checkOutput("rst_out_valid",     64'(out_valid),     64'(0));
        checkOutput("rst_out_instr",     64'(out_instr),     64'(0));
        checkOutput("rst_out_tag",       64'(out_tag),       64'(0));
        checkOutput("rst_stall_cnt",     64'(stall_cnt),     64'(0));
        mq.delete();
        mSb     = '0;
        tailCnt = 0;
        mStall  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clearScoreboard();
        for (int r = 1; r < NREG; r++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 5'(r));
        end
    endtask

    initial begin
        passCount   = 0;
        totalCount  = 0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_regwrite = 1'b0;
        in_alusrc   = 1'b0;
        out_ready   = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        #1;
        doReset();

        $display("[TB] fill window and overflow");
        for (int i = 0; i < BS + 1; i++) begin
            applyStimulus(1'b1, mkInstr(5'(i), 5'(i + 1), 5'(i + 2)), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        end

        $display("[TB] RAW hazard with out-of-order issue");
        applyStimulus(1'b1, mkInstr(5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, mkInstr(6, 5, 3), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, mkInstr(7, 8, 9), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        clearScoreboard();

        $display("[TB] WAR/WAW and x0 destinations");
        applyStimulus(1'b1, mkInstr(9, 4, 0), 1'b1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, mkInstr(4, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, mkInstr(4, 3, 3), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, mkInstr(0, 3, 3), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, mkInstr(10, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        end
        clearScoreboard();

        $display("[TB] wrap-around stream");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, mkInstr(5'($urandom), 5'($urandom), 5'($urandom)), 1'b0,
                          1'($urandom), 1'b1, 1'b0, '0);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          mkInstr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 7))),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                          5'($urandom_range(0, 7)));
        end
        clearScoreboard();

        $display("[TB] reset mid-traffic");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, mkInstr(5'(i + 1), 5'(i + 2), 5'(i + 3)), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        end
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, mkInstr(5'(i + 1), 0, 0), 1'b1, 1'b1, 1'b1, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
